// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one combinational ALU
// between two requesters, with per-op settle time and a tagged response.
module alu_arbiter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [2:0]       req1_sel,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zflag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zflag,
    output logic             rsp_divz
);

    localparam int MAXL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last_grant;
    logic            grant_vld;
    logic            grant_id;
    logic            op_id;
    logic            op_divz;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   lat_m1;
    logic [WIDTH-1:0] pick_op1;
    logic [WIDTH-1:0] pick_op2;
    logic [2:0]       pick_sel;

    // Round-robin grant, only offered while idle
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant_id;
    assign req1_ready = grant_vld && grant_id;

    // Operand mux for the granted requester and its settle count
    always_comb begin
        pick_op1 = grant_id ? req1_op1 : req0_op1;
        pick_op2 = grant_id ? req1_op2 : req0_op2;
        pick_sel = grant_id ? req1_sel : req0_sel;
        lat_m1   = '0;
        if (pick_sel == 3'b011) begin
            lat_m1 = CW'(MUL_CYCLES - 1);
        end else if (pick_sel == 3'b100) begin
            lat_m1 = CW'(DIV_CYCLES - 1);
        end
    end

    // Next-state logic for IDLE -> EXEC -> DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_vld) state_nxt = EXEC;
            EXEC: if (cnt == '0) state_nxt = DONE;
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, settle countdown and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            op_id      <= 1'b0;
            op_divz    <= 1'b0;
            cnt        <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_sel    <= 3'b000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zflag  <= 1'b0;
            rsp_divz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        alu_op1    <= pick_op1;
                        alu_op2    <= pick_op2;
                        alu_sel    <= pick_sel;
                        op_id      <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= lat_m1;
                        op_divz    <= (pick_sel == 3'b100) && (pick_op2 == '0);
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        rsp_valid  <= 1'b1;
                        rsp_id     <= op_id;
                        rsp_divz   <= op_divz;
                        rsp_result <= op_divz ? '0 : alu_result;
                        rsp_zflag  <= !op_divz && alu_zflag;
                    end
                end
                DONE: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus a randomized run checked
// against a timeline model of the arbiter.
module tb_alu_arbiter;

    localparam int W   = 32;
    localparam int MUL = 2;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [2:0]   req0_sel = '0, req1_sel = '0;
    logic [W-1:0] alu_op1, alu_op2, alu_result;
    logic [2:0]   alu_sel;
    logic         alu_zflag;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zflag, rsp_divz;
    logic [W-1:0] rsp_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zflag(alu_zflag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zflag(rsp_zflag), .rsp_divz(rsp_divz)
    );

    // Environment ALU: 000 add, 001 sub, 010 or, 011 mul, 100 div,
    // 101 and, 110 xor, 111 pass op1; divide by zero gives junk.
    function automatic logic [W-1:0] alu_fn(logic [2:0] s, logic [W-1:0] a, logic [W-1:0] b);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a | b;
            3'd3: return a * b;
            3'd4: return (b == 0) ? 32'hDEAD_BEEF : a / b;
            3'd5: return a & b;
            3'd6: return a ^ b;
            default: return a;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_sel, alu_op1, alu_op2);
        alu_zflag  = (alu_result != 0);
    end

    function automatic int lat(logic [2:0] s);
        if (s == 3'd3) return MUL;
        if (s == 3'd4) return DIV;
        return 1;
    endfunction

    task automatic set_req(input logic id, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] s);
        if (id) begin
            req1_valid = v; req1_op1 = a; req1_op2 = b; req1_sel = s;
        end else begin
            req0_valid = v; req0_op1 = a; req0_op2 = b; req0_sel = s;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Issue one op, measure cycles to rsp_valid, check operand hold and response
    task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] s, input logic [W-1:0] e_res, input logic e_zf,
                         input logic e_divz, input int e_wait, input string nm);
        int n;
        int k;
        @(posedge clk); #1;
        set_req(id, 1'b1, a, b, s);
        rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL %s_grant: no ready within 20 cycles", nm);
            set_req(id, 1'b0, a, b, s);
            return;
        end
        @(posedge clk); #1;
        set_req(id, 1'b0, '0, '0, 3'd0);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (rsp_valid) break;
            checks++;
            if ({alu_op1, alu_op2, alu_sel} !== {a, b, s}) begin
                errors++;
                $display("FAIL %s_hold: alu=%h/%h/%b need %h/%h/%b",
                         nm, alu_op1, alu_op2, alu_sel, a, b, s);
            end
        end
        checks++;
        if (k !== e_wait) begin
            errors++;
            $display("FAIL %s_latency: rsp_valid after %0d need %0d", nm, k, e_wait);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zflag, rsp_divz} !==
            {1'b1, id, e_res, e_zf, e_divz}) begin
            errors++;
            $display("FAIL %s_rsp: v=%b id=%b res=%0d z=%b dz=%b need 1 %b %0d %b %b",
                     nm, rsp_valid, rsp_id, rsp_result, rsp_zflag, rsp_divz,
                     id, e_res, e_zf, e_divz);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: r0=%b r1=%b rv=%b need 000", req0_ready, req1_ready, rsp_valid);
        end
        checks++;
        if ({alu_op1, alu_op2, alu_sel} !== '0) begin
            errors++;
            $display("FAIL reset_alu: %h %h %b need zeros", alu_op1, alu_op2, alu_sel);
        end
        checks++;
        if ({rsp_id, rsp_result, rsp_zflag, rsp_divz} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: id=%b res=%h z=%b dz=%b need zeros",
                     rsp_id, rsp_result, rsp_zflag, rsp_divz);
        end
    endtask

    task automatic test_add();
        do_reset();
        do_op(1'b0, 5, 7, 3'b000, 12, 1'b1, 1'b0, 2, "add");
    endtask

    task automatic test_alternate();
        logic gq[$];
        int nr;
        int c;
        do_reset();
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 9, 9, 3'b001);
        set_req(1'b1, 1'b1, 1, 2, 3'b010);
        rsp_ready = 1'b1;
        nr = 0;
        c = 0;
        while (nr < 4 && c < 60) begin
            @(negedge clk);
            c++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL alt_both_ready: both readies high");
            end
            if (req0_ready) gq.push_back(1'b0);
            if (req1_ready) gq.push_back(1'b1);
            if (rsp_valid) begin
                nr++;
                checks++;
                if (rsp_id ? ({rsp_result, rsp_zflag} !== {32'd3, 1'b1})
                           : ({rsp_result, rsp_zflag} !== {32'd0, 1'b0})) begin
                    errors++;
                    $display("FAIL alt_rsp: id=%b res=%0d z=%b need %s",
                             rsp_id, rsp_result, rsp_zflag, rsp_id ? "3 1" : "0 0");
                end
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (nr != 4 || gq.size() < 4) begin
            errors++;
            $display("FAIL alt_count: rsps=%0d grants=%0d need 4 4", nr, gq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gq[i] !== logic'(i % 2)) begin
                    errors++;
                    $display("FAIL alt_grant%0d: got %b need %0d", i, gq[i], i % 2);
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        do_op(1'b1, 6, 7, 3'b011, 42, 1'b1, 1'b0, 3, "mul");
    endtask

    task automatic test_div();
        do_op(1'b0, 100, 0, 3'b100, 0, 1'b0, 1'b1, 5, "div0");
        do_op(1'b0, 100, 4, 3'b100, 25, 1'b1, 1'b0, 5, "div");
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b1, 3, 4, 3'b000);
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_grant1: req1_ready=%b need 1", req1_ready);
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, '0, '0, 3'd0);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 10, 3, 3'b001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, req0_ready} !== {1'b1, 1'b1, 32'd7, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d: v=%b id=%b res=%0d r0=%b need 1 1 7 0",
                         i, rsp_valid, rsp_id, rsp_result, req0_ready);
            end
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: v=%b r0=%b need 1 0", rsp_valid, req0_ready);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_regrant: v=%b r0=%b need 0 1", rsp_valid, req0_ready);
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, '0, '0, 3'd0);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd7}) begin
            errors++;
            $display("FAIL bp_second: v=%b id=%b res=%0d need 1 0 7", rsp_valid, rsp_id, rsp_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 100, 4, 3'b100);
        @(negedge clk);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, '0, '0, 3'd0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, req0_ready, req1_ready, alu_op1, alu_op2, alu_sel, rsp_result} !== '0) begin
            errors++;
            $display("FAIL rmid_outs: rv=%b alu=%h/%h/%b res=%h need zeros",
                     rsp_valid, alu_op1, alu_op2, alu_sel, rsp_result);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_norsp%0d: rsp_valid=%b need 0", i, rsp_valid);
            end
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1, 1, 3'b000);
        set_req(1'b1, 1'b1, 2, 2, 3'b000);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rmid_grant: r0=%b r1=%b need 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd2}) begin
            errors++;
            $display("FAIL rmid_rsp: v=%b id=%b res=%0d need 1 0 2", rsp_valid, rsp_id, rsp_result);
        end
        @(posedge clk); #1;
    endtask

    // Random traffic against a timeline model: idle arbiter grants the
    // only valid requester or the one not served last; response appears
    // lat+1 cycles after the grant cycle and stays until accepted.
    task automatic test_random();
        logic [W-1:0] pa[2], pb[2];
        logic [2:0]   ps[2];
        bit           pv[2];
        bit           m_idle, m_last, gv, g, erv;
        int           due;
        logic         e_id, e_zf, e_dz;
        logic [W-1:0] e_res;
        do_reset();
        pv[0] = 0; pv[1] = 0;
        m_idle = 1; m_last = 1; due = 0;
        e_id = 0; e_zf = 0; e_dz = 0; e_res = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (!pv[i]) begin
                    if ($urandom_range(2) == 0) begin
                        pv[i] = 1;
                        pa[i] = $urandom_range(300);
                        pb[i] = ($urandom_range(3) == 0) ? 0 : $urandom_range(20);
                        ps[i] = 3'($urandom_range(7));
                    end
                end else if ($urandom_range(9) == 0) begin
                    pv[i] = 0;
                end
                set_req(1'(i), pv[i], pa[i], pb[i], ps[i]);
            end
            rsp_ready = 1'($urandom_range(1));
            @(negedge clk);
            gv = m_idle && (pv[0] || pv[1]);
            g  = (pv[0] && pv[1]) ? !m_last : pv[1] && !pv[0];
            checks++;
            if ({req0_ready, req1_ready} !== {gv && !g, gv && g}) begin
                errors++;
                $display("FAIL rnd_ready c%0d: r0=%b r1=%b need %b %b",
                         c, req0_ready, req1_ready, gv && !g, gv && g);
            end
            erv = !m_idle && (c >= due);
            checks++;
            if (rsp_valid !== erv) begin
                errors++;
                $display("FAIL rnd_valid c%0d: rsp_valid=%b need %b", c, rsp_valid, erv);
            end else if (erv) begin
                checks++;
                if ({rsp_id, rsp_result, rsp_zflag, rsp_divz} !== {e_id, e_res, e_zf, e_dz}) begin
                    errors++;
                    $display("FAIL rnd_rsp c%0d: id=%b res=%h z=%b dz=%b need %b %h %b %b",
                             c, rsp_id, rsp_result, rsp_zflag, rsp_divz, e_id, e_res, e_zf, e_dz);
                end
            end
            if (gv) begin
                m_idle = 0;
                m_last = g;
                e_id   = g;
                e_dz   = (ps[g] == 3'd4) && (pb[g] == 0);
                e_res  = e_dz ? '0 : alu_fn(ps[g], pa[g], pb[g]);
                e_zf   = (e_res != 0);
                due    = c + lat(ps[g]) + 1;
                pv[g]  = 0;
            end else if (erv && rsp_ready) begin
                m_idle = 1;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_alternate();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
